// File: rtl/argmax_row_engine.sv
// Row-wise argmax over FEATURE_COLS signed scores per row, FEATURE_ROWS rows per run.
// Latency: FEATURE_COLS+2 cycles per row (scan, drain, write); done one cycle after the last write.
// Backpressure: none; memory returns data one cycle after the read strobe, start ignored while busy.
module argmax_row_engine #(
  parameter int FEATURE_ROWS = 6,
  parameter int FEATURE_COLS = 3,
  parameter int DATA_WIDTH   = 16,
  parameter int COL_W        = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [2:0]                    argmax_row_count,
  output logic                          enable_argmax_row_counter,
  output logic                          fm_read_en,
  output logic [2:0]                    fm_read_row,
  output logic [COL_W-1:0]              fm_read_col,
  input  logic [DATA_WIDTH-1:0]         fm_read_data,
  output logic [FEATURE_ROWS*COL_W-1:0] argmax_result,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FEATURE_COLS - 1);
  localparam logic [2:0]       LAST_ROW = 3'(FEATURE_ROWS - 1);

  state_t                          r_state;
  state_t                          w_next;
  logic [COL_W-1:0]                r_col;
  logic                            r_rd_vld;
  logic [COL_W-1:0]                r_rd_col;
  logic signed [DATA_WIDTH-1:0]    r_best_val;
  logic [COL_W-1:0]                r_best_idx;
  logic [FEATURE_ROWS*COL_W-1:0]   r_result;
  logic                            w_start_run;
  logic                            w_last_col;
  logic                            w_last_row;

  assign w_start_run = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_row  = (argmax_row_count == LAST_ROW);

  // The row address is owned by the external counter and passed straight through.
  assign fm_read_row   = argmax_row_count;
  assign fm_read_col   = r_col;
  assign argmax_result = r_result;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SCAN;
      S_SCAN:  if (w_last_col) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: w_next = w_last_row ? S_DONE : S_SCAN;
      S_DONE:  if (start) w_next = S_SCAN;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state only.
  always_comb begin
    fm_read_en                = 1'b0;
    enable_argmax_row_counter = 1'b0;
    busy                      = 1'b0;
    done                      = 1'b0;
    case (r_state)
      S_SCAN:  begin fm_read_en = 1'b1; busy = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_WRITE: begin enable_argmax_row_counter = 1'b1; busy = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Column address: restarts at 0 for every row, steps once per scan cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
    end else if (w_start_run || (r_state == S_WRITE)) begin
      r_col <= '0;
    end else if (r_state == S_SCAN) begin
      r_col <= w_last_col ? '0 : r_col + 1'b1;
    end
  end

  // Remember which column each read targeted so the returning score can be tagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_vld <= 1'b0;
      r_rd_col <= '0;
    end else begin
      r_rd_vld <= (r_state == S_SCAN);
      r_rd_col <= r_col;
    end
  end

  // Running maximum: column 0 seeds it, later columns win only when strictly greater.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_best_val <= '0;
      r_best_idx <= '0;
    end else if (r_rd_vld) begin
      if ((r_rd_col == '0) || ($signed(fm_read_data) > r_best_val)) begin
        r_best_val <= $signed(fm_read_data);
        r_best_idx <= r_rd_col;
      end
    end
  end

  // Result slots: cleared on each accepted start, one slot filled per write cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
    end else if (w_start_run) begin
      r_result <= '0;
    end else if (r_state == S_WRITE) begin
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        if (argmax_row_count == 3'(r)) begin
          r_result[r*COL_W +: COL_W] <= r_best_idx;
        end
      end
    end
  end

endmodule
